store_bus_ctrl: RTL and testbench
=================================

# store_bus_ctrl

Bus-side write engine that sits directly downstream of the store unit's busy tracker. It accepts store requests (address, data, size) into a small in-order buffer and drives each one onto the data bus as a single write transaction with a req/ack handshake. It returns a one-cycle `store_done` pulse per retired store, which clears the store unit's `busy`. Misaligned stores, bus errors and bus timeouts retire with `st_err` and never hang the pipeline.

## Interface
- `DEPTH`, 4: store buffer entries, power of two, ≥2.
- `TIMEOUT`, 255: maximum cycles in REQ before forced retire, 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: store request valid.
- `st_addr` in 32: byte address.
- `st_data` in 32: store data, LSB-justified.
- `st_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = treated as misaligned.
- `st_ready` out 1: buffer can accept; equals !full.
- `store_done` out 1: one-cycle pulse per retired store.
- `st_err` out 1: qualifies `store_done`; 1 = misaligned, bus error or timeout.
- `bus_req` out 1: write request.
- `bus_we` out 1: always 1 while `bus_req`=1, 0 otherwise.
- `bus_addr` out 32: word-aligned address, `{st_addr[31:2],2'b00}`.
- `bus_wdata` out 32: lane-replicated data.
- `bus_be` out 4: byte enables.
- `bus_ack` in 1: write accepted and completed this cycle.
- `bus_err` in 1: write failed this cycle.

## Operation
- Buffer: FIFO of DEPTH entries {addr, data, size, mis}. Push on `st_valid && st_ready`. Pop when the head retires.
- `st_ready` depends only on full. When full, no push occurs even if a pop happens in the same cycle.
- Misalignment is computed at push: half with addr[0]=1, word with addr[1:0]≠0, or size=3.
- Lane formatting, computed at launch:
  - byte: wdata = {4{data[7:0]}}, be = 4'b0001 << addr[1:0].
  - half: wdata = {2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata = data, be = 4'b1111.
- FSM states:
  - IDLE:
    - Head non-empty and mis=0: latch bus regs, clear timer, go to REQ.
    - Head non-empty and mis=1: pop, pulse `store_done`+`st_err`, stay in IDLE, no bus activity.
  - REQ: `bus_req`=1. Address, data and be are held stable. Timer increments each cycle.
    - `bus_err`: retire with error.
    - Else `bus_ack`: retire OK.
    - Else timer = TIMEOUT-1: retire with error (timeout).
    - In every case: pop, go to IDLE.
- `bus_err` has priority over `bus_ack` when both are high.
- Stores retire strictly in acceptance order. At most one bus transaction is outstanding.

## Timing
- Reset values: `st_ready`=1, `store_done`=0, `st_err`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_be`=0. FIFO is empty, state is IDLE, timer is 0.
- Reset mid-transaction drops `bus_req` asynchronously, discards all entries, and produces no `store_done`.
- All outputs are registered.
- Push at edge E: head is visible after E. Launch at edge E+1, so `bus_req` is high from E+1.
- Ack sampled at edge A: after A, `bus_req`=0 and `store_done`=1 for exactly one cycle.
- Zero-wait ack gives `store_done` high after edge E+2.
- Back-to-back stores: the next `bus_req` rises after A+1, giving one idle bus cycle between transactions.
- Misaligned head: `store_done` is high after the edge following its push, and the next head is examined the cycle after.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles, then `store_done`+`st_err` are asserted.
- `st_err` is 0 whenever `store_done` is 0.

## Test plan
- **Word store, zero-wait ack:** push addr 0x1000_0004, data 0xDEADBEEF, size 2.
  - Expect `bus_req` 1 cycle, bus_addr 0x1000_0004, be 1111, wdata 0xDEADBEEF.
  - `store_done`=1 and `st_err`=0 two cycles after the push edge.
- **Byte/half lanes:** byte at addr 0x13, data 0xA5 → be 1000, wdata 0xA5A5A5A5. Half at addr 0x22, data 0x1234 → be 1100, wdata 0x12341234.
- **Misaligned:** word at addr 0x02 → no `bus_req`, `store_done`+`st_err` one cycle after push. A following valid store still launches normally.
- **Fill/backpressure:** hold `bus_ack`=0 and push 5 stores with DEPTH=4.
  - `st_ready` drops after the 4th push; the 5th is held.
  - Release ack: four `store_done` pulses in order, each one cycle after its ack; the 5th store is accepted once not full.
- **Error/timeout:**
  - `bus_ack`=`bus_err`=1 together → error retire.
  - TIMEOUT=8 with no ack → `bus_req` high exactly 8 cycles, then `store_done`+`st_err`.
- **Reset mid-op:** assert `rst_n`=0 while `bus_req`=1 with 3 entries queued → `bus_req`=0 immediately and `st_ready`=1. After release, no `store_done` pulses.

Source files
------------

// File: rtl/store_bus_ctrl.sv
// store_bus_ctrl: in-order store buffer that drives one req/ack write transaction at a time.
// Misaligned stores, bus errors and timeouts retire with st_err so the store pipeline never hangs.
module store_bus_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_ready,
    output logic        store_done,
    output logic        st_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic        bus_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [7:0]    TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Handshakes: a store is accepted on every edge where st_valid && st_ready (st_ready is
    // simply !full, never a function of a same-cycle pop); the bus side holds bus_req and its
    // address/data/enables stable until bus_ack, bus_err or the timeout retires the head.
    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [1:0]    size_mem [DEPTH];
    logic          mis_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    timer_q, timer_d;

    logic          st_ready_q, st_ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          bus_req_q, bus_req_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_be_q, bus_be_d;

    logic          push, pop, launch;
    logic          empty, mis_in, timeout_hit;
    logic [31:0]   head_addr, head_data;
    logic [1:0]    head_size;
    logic          head_mis;
    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_be;

    assign push        = st_valid && st_ready_q;
    assign empty       = (count_q == '0);
    assign timeout_hit = (timer_q == TIMER_LAST);

    assign mis_in = (st_size == 2'd3) ||
                    ((st_size == 2'd1) && st_addr[0]) ||
                    ((st_size == 2'd2) && (st_addr[1:0] != 2'b00));

    assign head_addr = addr_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];
    assign head_size = size_mem[rd_ptr_q];
    assign head_mis  = mis_mem[rd_ptr_q];

    // Storage has no reset: occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= st_addr;
            data_mem[wr_ptr_q] <= st_data;
            size_mem[wr_ptr_q] <= st_size;
            mis_mem[wr_ptr_q]  <= mis_in;
        end
    end

    always_comb begin
        fmt_wdata = head_data;
        fmt_be    = 4'b1111;
        case (head_size)
            2'd0: begin
                fmt_wdata = {4{head_data[7:0]}};
                fmt_be    = 4'b0001 << head_addr[1:0];
            end
            2'd1: begin
                fmt_wdata = {2{head_data[15:0]}};
                fmt_be    = head_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                fmt_wdata = head_data;
                fmt_be    = 4'b1111;
            end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty && !head_mis) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_err || bus_ack || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs and datapath controls
    always_comb begin
        pop    = 1'b0;
        launch = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (head_mis) begin
                        pop    = 1'b1;
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus_err) begin
                    pop    = 1'b1;
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else if (bus_ack) begin
                    pop    = 1'b1;
                    done_d = 1'b1;
                end else if (timeout_hit) begin
                    pop    = 1'b1;
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            default: begin
                pop    = 1'b0;
                launch = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (launch) begin
            timer_d = 8'd0;
        end else if ((state_q == S_REQ) && !pop) begin
            timer_d = timer_q + 8'd1;
        end
    end

    // Bus registers load only at launch, so they stay stable for the whole request.
    always_comb begin
        st_ready_d  = (count_d != FULL_CNT);
        bus_req_d   = (state_d == S_REQ);
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        if (launch) begin
            bus_addr_d  = {head_addr[31:2], 2'b00};
            bus_wdata_d = fmt_wdata;
            bus_be_d    = fmt_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= 8'd0;
            st_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            st_ready_q  <= st_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
        end
    end

    assign st_ready   = st_ready_q;
    assign store_done = done_q;
    assign st_err     = err_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_req_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;

endmodule

// File: tb/tb_store_bus_ctrl.sv
// Bench for store_bus_ctrl: random and directed stores, a randomised bus responder,
// and a scoreboard monitor comparing every launch and retire with a behavioural model.
module tb_store_bus_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic        st_ready, store_done, st_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  store_bus_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_ready(st_ready), .store_done(store_done), .st_err(st_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  st_t         store_q[$];   // accepted, not yet retired
  logic [0:0]  exp_q[$];     // expected st_err per bus transaction
  int          len_q[$];     // expected bus_req length per bus transaction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing expected=present", name);
  endtask

  // reference model
  function automatic bit is_mis(input st_t s);
    case (s.size)
      2'd0: return 1'b0;
      2'd1: return (s.addr % 2) != 0;
      2'd2: return (s.addr % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input st_t s);
    case (s.size)
      2'd0: return (s.data & 32'hFF) * 32'h0101_0101;
      2'd1: return (s.data & 32'hFFFF) * 32'h0001_0001;
      default: return s.data;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input st_t s);
    int off;
    off = int'(s.addr % 4);
    case (s.size)
      2'd0: return 4'(1 << off);
      2'd1: return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  // bus responder: kind 0 ack, 1 err, 2 ack+err, 3 silent (timeout)
  int force_en = 0, force_kind = 0, force_wait = 0;
  bit resp_active = 1'b0;
  int resp_kind = 0, resp_wait = 0, resp_cnt = 0;

  always @(negedge clk) begin
    if (!bus_req) begin
      resp_active = 1'b0;
      bus_ack = 1'b0;
      bus_err = 1'b0;
    end else begin
      if (!resp_active) begin
        int r;
        resp_active = 1'b1;
        resp_cnt = 0;
        if (force_en != 0) begin
          resp_kind = force_kind;
          resp_wait = force_wait;
        end else begin
          r = $urandom_range(0, 9);
          resp_kind = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
          resp_wait = $urandom_range(0, 3);
        end
        exp_q.push_back(resp_kind != 0);
        len_q.push_back(resp_kind == 3 ? TIMEOUT : resp_wait + 1);
      end
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (resp_kind != 3 && resp_cnt == resp_wait) begin
        bus_ack = (resp_kind == 0 || resp_kind == 2);
        bus_err = (resp_kind == 1 || resp_kind == 2);
      end
      resp_cnt++;
    end
  end

  // scoreboard monitor
  bit          prev_req = 1'b0;
  int          req_len = 0;
  int          done_cnt = 0;
  st_t         mon_s;
  logic [31:0] l_addr, l_wdata;
  logic [3:0]  l_be;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      req_len = 0;
    end else begin
      check("err_qualified", st_err & ~store_done, 0);
      check("bus_we", bus_we, bus_req);
      if (bus_req && !prev_req) begin
        if (store_q.size() == 0) begin
          fail_now("launch_without_store");
        end else begin
          mon_s = store_q[0];
          check("launch_aligned", is_mis(mon_s), 0);
          check("bus_addr", bus_addr, mon_s.addr & 32'hFFFF_FFFC);
          check("bus_wdata", bus_wdata, exp_wdata(mon_s));
          check("bus_be", bus_be, exp_be(mon_s));
          l_addr = bus_addr;
          l_wdata = bus_wdata;
          l_be = bus_be;
        end
        req_len = 1;
      end else if (bus_req) begin
        req_len++;
        check("addr_stable", bus_addr, l_addr);
        check("wdata_stable", bus_wdata, l_wdata);
        check("be_stable", bus_be, l_be);
      end
      if (!bus_req && prev_req) begin
        if (len_q.size() == 0) fail_now("req_len_model");
        else check("req_len", req_len, len_q.pop_front());
      end
      if (store_done) begin
        done_cnt++;
        if (store_q.size() == 0) begin
          fail_now("done_expected_store");
        end else begin
          mon_s = store_q.pop_front();
          if (is_mis(mon_s)) begin
            check("mis_err", st_err, 1);
            check("mis_no_bus", prev_req, 0);
          end else begin
            check("done_after_req", prev_req && !bus_req, 1);
            if (exp_q.size() == 0) fail_now("err_model");
            else check("st_err", st_err, exp_q.pop_front());
          end
        end
      end
      check("st_ready", st_ready, store_q.size() < DEPTH);
      prev_req = bus_req;
    end
  end

  // driver tasks
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    st_t s;
    n = 0;
    @(negedge clk);
    st_valid = 1'b1;
    st_addr = a;
    st_data = d;
    st_size = sz;
    while (!st_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) begin
      fail_now("push_accept_timeout");
      st_valid = 1'b0;
      return;
    end
    @(posedge clk);
    s.addr = a;
    s.data = d;
    s.size = sz;
    store_q.push_back(s);
    #1 st_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((store_q.size() != 0 || bus_req) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (store_q.size() != 0 || bus_req) fail_now("drain_timeout");
    idle_cycles(2);
  endtask

  task automatic report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    #500000;
    fail_now("global_timeout");
    report();
    $finish;
  end

  initial begin
    int base;
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_st_ready", st_ready, 1);
    check("rst_store_done", store_done, 0);
    check("rst_st_err", st_err, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_be", bus_be, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // word store, zero-wait ack
    force_en = 1; force_kind = 0; force_wait = 0;
    push_store(32'h1000_0004, 32'hDEAD_BEEF, 2'd2);
    @(negedge clk);
    check("word_no_req_yet", bus_req, 0);
    @(negedge clk);
    check("word_req", bus_req, 1);
    check("word_addr", bus_addr, 32'h1000_0004);
    check("word_be", bus_be, 4'b1111);
    check("word_wdata", bus_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("word_done", store_done, 1);
    check("word_err", st_err, 0);
    check("word_req_low", bus_req, 0);
    wait_drain();

    // byte / half lanes
    push_store(32'h0000_0013, 32'h0000_00A5, 2'd0);
    idle_cycles(2);
    check("byte_be", bus_be, 4'b1000);
    check("byte_wdata", bus_wdata, 32'hA5A5_A5A5);
    wait_drain();
    push_store(32'h0000_0022, 32'h0000_1234, 2'd1);
    idle_cycles(2);
    check("half_be", bus_be, 4'b1100);
    check("half_wdata", bus_wdata, 32'h1234_1234);
    wait_drain();

    // misaligned word, then a normal store
    push_store(32'h0000_0002, 32'h1111_2222, 2'd2);
    @(negedge clk);
    check("mis_done_not_yet", store_done, 0);
    @(negedge clk);
    check("mis_done", store_done, 1);
    check("mis_st_err", st_err, 1);
    check("mis_bus_idle", bus_req, 0);
    push_store(32'h0000_0040, 32'h5555_AAAA, 2'd2);
    wait_drain();

    // fill / backpressure
    force_wait = 5;
    for (int i = 0; i < 4; i++) push_store(32'h0000_0100 + 32'(4 * i), 32'(i + 1), 2'd2);
    @(negedge clk);
    check("full_st_ready", st_ready, 0);
    push_store(32'h0000_0200, 32'h0000_0005, 2'd2);
    wait_drain();

    // error priority and explicit error
    force_kind = 2; force_wait = 1;
    push_store(32'h0000_0300, 32'hCAFE_F00D, 2'd2);
    wait_drain();
    force_kind = 1; force_wait = 0;
    push_store(32'h0000_0301, 32'h0000_0077, 2'd0);
    wait_drain();

    // timeout
    force_kind = 3;
    push_store(32'h0000_0400, 32'h0BAD_0BAD, 2'd2);
    wait_drain();

    // randomised traffic
    force_en = 0;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      push_store(a, $urandom, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    wait_drain();

    // reset mid-transaction with three entries queued
    force_en = 1; force_kind = 0; force_wait = 6;
    for (int i = 0; i < 3; i++) push_store(32'h0000_0500 + 32'(4 * i), 32'(i + 9), 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_bus_req", bus_req, 0);
    check("rstmid_st_ready", st_ready, 1);
    check("rstmid_store_done", store_done, 0);
    store_q.delete();
    exp_q.delete();
    len_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    base = done_cnt;
    idle_cycles(20);
    check("rstmid_no_done", done_cnt - base, 0);
    check("rstmid_idle_req", bus_req, 0);

    report();
    $finish;
  end
endmodule
